fp_add_sched: RTL

//  Round-robin scheduler sharing one fixed-latency FP add pipe among NUM_REQ requesters.

---
 rtl/fp_add_sched.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/fp_add_sched.sv
`default_nettype none
// ============================================================================
// Module      : fp_add_sched
// Description : Round-robin scheduler sharing one fixed-latency FP add pipe
//               among NUM_REQ requesters, with a tagged response bus.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_add_sched #(
    parameter int WIDTH    = 24,
    parameter int NUM_REQ  = 4,
    parameter int PIPE_LAT = 3,
    parameter int IDW      = $clog2(NUM_REQ)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [NUM_REQ-1:0]       req_valid_i,
    output logic [NUM_REQ-1:0]       req_ready_o,
    input  logic [NUM_REQ*WIDTH-1:0] req_a_i,
    input  logic [NUM_REQ*WIDTH-1:0] req_b_i,
    input  logic [NUM_REQ*4-1:0]     req_op_i,
    input  logic                     flush_i,
    output logic [WIDTH-1:0]         pipe_a_o,
    output logic [WIDTH-1:0]         pipe_b_o,
    output logic [3:0]               pipe_op_o,
    input  logic [WIDTH-1:0]         pipe_result_i,
    output logic                     rsp_valid_o,
    output logic [IDW-1:0]           rsp_id_o,
    output logic [WIDTH-1:0]         rsp_result_o,
    output logic                     rsp_err_o,
    output logic                     busy_o
);

    // One stage per edge between handshake and the response register load.
    localparam int C_DEPTH = PIPE_LAT + 2;

    typedef struct packed {
        logic           valid;
        logic [IDW-1:0] id;
        logic           err;
    } tag_t;

    function automatic logic op_legal(input logic [3:0] op);
        case (op)
            4'b0000, 4'b0100, 4'b0001, 4'b0010, 4'b1000, 4'b1001: op_legal = 1'b1;
            default:                                              op_legal = 1'b0;
        endcase
    endfunction

    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [WIDTH-1:0] pipe_a_q, pipe_a_d, pipe_b_q, pipe_b_d;
    logic [3:0]       pipe_op_q, pipe_op_d;
    tag_t             trk_q [C_DEPTH];
    tag_t             trk_d [C_DEPTH];
    logic             rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
    logic [IDW-1:0]   rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0] rsp_result_q, rsp_result_d;

    logic             gnt_valid;
    logic [IDW-1:0]   gnt_idx;
    logic [IDW-1:0]   cand;
    logic [3:0]       sel_op;
    logic             sel_legal;

    always_comb begin
        gnt_valid   = 1'b0;
        gnt_idx     = '0;
        cand        = '0;
        req_ready_o = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDW'((int'(ptr_q) + k) % NUM_REQ);
            if (!gnt_valid && req_valid_i[cand]) begin
                gnt_valid = 1'b1;
                gnt_idx   = cand;
            end
        end
        if (flush_i) begin
            gnt_valid = 1'b0;
        end
        if (gnt_valid) begin
            req_ready_o[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        sel_op    = req_op_i[gnt_idx*4 +: 4];
        sel_legal = op_legal(sel_op);

        ptr_d     = gnt_valid ? gnt_idx : ptr_q;
        pipe_a_d  = pipe_a_q;
        pipe_b_d  = pipe_b_q;
        pipe_op_d = pipe_op_q;
        // Illegal ops never reach the pipe; their tag alone carries the error.
        if (gnt_valid && sel_legal) begin
            pipe_a_d  = req_a_i[gnt_idx*WIDTH +: WIDTH];
            pipe_b_d  = req_b_i[gnt_idx*WIDTH +: WIDTH];
            pipe_op_d = sel_op;
        end

        trk_d[0].valid = gnt_valid;
        trk_d[0].id    = gnt_valid ? gnt_idx : '0;
        trk_d[0].err   = gnt_valid & ~sel_legal;
        for (int i = 1; i < C_DEPTH; i++) begin
            trk_d[i] = trk_q[i-1];
        end

        rsp_valid_d  = trk_q[C_DEPTH-1].valid;
        rsp_id_d     = trk_q[C_DEPTH-1].valid ? trk_q[C_DEPTH-1].id : '0;
        rsp_err_d    = trk_q[C_DEPTH-1].valid & trk_q[C_DEPTH-1].err;
        rsp_result_d = (trk_q[C_DEPTH-1].valid && !trk_q[C_DEPTH-1].err) ? pipe_result_i : '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q        <= IDW'(NUM_REQ - 1);
            pipe_a_q     <= '0;
            pipe_b_q     <= '0;
            pipe_op_q    <= '0;
            for (int i = 0; i < C_DEPTH; i++) begin
                trk_q[i] <= '0;
            end
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            ptr_q        <= ptr_d;
            pipe_a_q     <= pipe_a_d;
            pipe_b_q     <= pipe_b_d;
            pipe_op_q    <= pipe_op_d;
            for (int i = 0; i < C_DEPTH; i++) begin
                trk_q[i] <= trk_d[i];
            end
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    always_comb begin
        busy_o = gnt_valid;
        for (int i = 0; i < C_DEPTH; i++) begin
            busy_o = busy_o | trk_q[i].valid;
        end
    end

    assign pipe_a_o     = pipe_a_q;
    assign pipe_b_o     = pipe_b_q;
    assign pipe_op_o    = pipe_op_q;
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_id_o     = rsp_id_q;
    assign rsp_result_o = rsp_result_q;
    assign rsp_err_o    = rsp_err_q;

endmodule
`default_nettype wire
